cov_toggle_collector: RTL and testbench
=======================================

COV_TOGGLE_COLLECTOR -- requirements
Module: cov_toggle_collector

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of monitored channels (1..64).
REQ-002 SHALL have parameter WIDTH, default 8, bits per channel (1..64).
REQ-003 SHALL have parameter CNT_W, default 16, per-channel toggle counter width (2..32).
REQ-004 SHALL have parameter THRESH, default 1, minimum count (1..2^CNT_W-1) for a channel to be counted as covered.
REQ-005 SHALL use reset reset, synchronous, active-high; clock clock.
REQ-006 clock  in  1  sampling clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 cov_en  in  1  sampling enable; low freezes all counters and history.
REQ-009 sample_in  in  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 clear_req  in  1  single-cycle pulse; zeroes all counters and un-primes history.
REQ-011 scan_req  in  1  single-cycle pulse; starts a coverage summary scan.
REQ-012 scan_busy  out  1  high while the scan FSM is not IDLE.
REQ-013 summary_valid  out  1  one-cycle pulse when covered_cnt is updated.
REQ-014 covered_cnt  out  clog2(NUM_CH+1)  channels with count >= THRESH at the last completed scan.
REQ-015 all_covered  out  1  covered_cnt == NUM_CH, updated with covered_cnt.
REQ-016 rd_req  in  1  counter readout request.
REQ-017 rd_idx  in  clog2(NUM_CH), min 1  channel to read.
REQ-018 rd_valid  out  1  readout response valid, exactly one cycle after rd_req.
REQ-019 rd_cnt  out  CNT_W  counter value of the requested channel.
REQ-020 rd_err  out  1  asserted with rd_valid when rd_idx >= NUM_CH.

Function
REQ-021 Per channel SHALL hold last[WIDTH], primed (1 bit) and cnt[CNT_W].
REQ-022 On a cycle with cov_en=1: if primed and sample != last, cnt SHALL increment by 1; last SHALL load sample; primed SHALL set.
REQ-023 The first enabled cycle after reset or clear SHALL only prime (no increment), so startup values never count as toggles.
REQ-024 cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 With cov_en=0, last, primed and cnt SHALL hold.
REQ-026 A toggle is counted once per cycle per channel, regardless of how many bits differ.
REQ-027 clear_req SHALL take effect on the next edge: all cnt=0, all primed=0; clear wins over a simultaneous toggle.
REQ-028 Scan FSM states IDLE, SCAN, DONE; IDLE->SCAN on scan_req, clearing the accumulator and scan index to 0.
REQ-029 SCAN SHALL examine one channel per cycle (index 0..NUM_CH-1), adding 1 when cnt >= THRESH, using the cnt value of that cycle.
REQ-030 SCAN->DONE after index NUM_CH-1; DONE SHALL register covered_cnt/all_covered, pulse summary_valid, and return to IDLE.
REQ-031 Scan latency SHALL be NUM_CH+1 cycles from scan_req to summary_valid.
REQ-032 scan_req while scan_busy=1 SHALL be ignored.
REQ-033 clear_req during SCAN or DONE SHALL abort to IDLE with no summary_valid; covered_cnt keeps its previous value.
REQ-034 Readout SHALL register the cnt value present in the rd_req cycle (pre-update); rd_err=1 and rd_cnt=0 when rd_idx >= NUM_CH.
REQ-035 Readout SHALL be independent of scan and clear state; back-to-back rd_req every cycle SHALL be supported.

Reset
REQ-036 During reset all cnt=0, primed=0, last=0, FSM=IDLE.
REQ-037 Reset values: scan_busy=0, summary_valid=0, covered_cnt=0, all_covered=0, rd_valid=0, rd_cnt=0, rd_err=0.
REQ-038 Reset SHALL override clear_req, scan_req, rd_req and cov_en in the same cycle.

Verification
REQ-039 Defaults; cov_en=1, ch0 alternates 0x00/0xFF for 5 enabled cycles, others constant -> rd_idx=0 gives rd_cnt=4, rd_idx=1 gives 0.
REQ-040 CNT_W=2, ch2 toggles every cycle for 10 cycles -> rd_cnt saturates at 3, no wrap.
REQ-041 ch0, ch3 toggled once each, scan_req -> summary_valid exactly 9 cycles later, covered_cnt=2, all_covered=0; all 8 toggled -> covered_cnt=8, all_covered=1.
REQ-042 scan_req, clear_req 4 cycles later -> no summary_valid, scan_busy=0 next cycle, counters 0, covered_cnt unchanged; first post-clear sample does not count.
REQ-043 THRESH=3, ch1 toggled twice then scan -> covered_cnt excludes ch1; third toggle and rescan -> includes ch1.
REQ-044 NUM_CH=6, rd_idx=7 -> rd_valid=1, rd_err=1, rd_cnt=0; cov_en=0 with changing inputs -> all counters unchanged.

Source files
------------

// File: rtl/cov_toggle_collector.sv
// rtl/cov_toggle_collector.sv - per-channel toggle counters with coverage summary scan and readout
//
// Ports:
//   clock, reset        sampling clock, synchronous active-high reset
//   cov_en              sampling enable; low freezes counters and history
//   sample_in           NUM_CH channels, channel k at [k*WIDTH +: WIDTH]
//   clear_req           pulse: zero all counters, un-prime history, abort a scan
//   scan_req            pulse: start a coverage summary scan (ignored while busy)
//   scan_busy           scan FSM not idle
//   summary_valid       one-cycle pulse when covered_cnt/all_covered update
//   covered_cnt         channels with count >= THRESH at the last completed scan
//   all_covered         covered_cnt == NUM_CH
//   rd_req, rd_idx      counter readout request and channel index
//   rd_valid            readout response, one cycle after rd_req
//   rd_cnt, rd_err      counter value; rd_err flags an out-of-range index
module cov_toggle_collector #(
    parameter int          NUM_CH = 8,
    parameter int          WIDTH  = 8,
    parameter int          CNT_W  = 16,
    parameter int unsigned THRESH = 1,
    localparam int         SUM_W  = $clog2(NUM_CH + 1),
    localparam int         IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cov_en,
    input  logic [NUM_CH*WIDTH-1:0] sample_in,
    input  logic                    clear_req,
    input  logic                    scan_req,
    output logic                    scan_busy,
    output logic                    summary_valid,
    output logic [SUM_W-1:0]        covered_cnt,
    output logic                    all_covered,
    input  logic                    rd_req,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic                    rd_valid,
    output logic [CNT_W-1:0]        rd_cnt,
    output logic                    rd_err
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    logic [WIDTH-1:0] last_q   [NUM_CH];
    logic [CNT_W-1:0] cnt_q    [NUM_CH];
    logic             primed_q [NUM_CH];

    state_t           state_q;
    logic [IDX_W-1:0] scan_idx_q;
    logic [SUM_W-1:0] acc_q;

    logic [CNT_W-1:0] rd_sel;
    logic             rd_hit;
    logic [CNT_W-1:0] scan_sel;
    logic             scan_hit;

    // Per-channel history. The first enabled sample after reset/clear only
    // primes, so arbitrary startup values never register as toggles.
    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (reset) begin
                cnt_q[k]    <= '0;
                primed_q[k] <= 1'b0;
                last_q[k]   <= '0;
            end else if (clear_req) begin
                cnt_q[k]    <= '0;
                primed_q[k] <= 1'b0;
            end else if (cov_en) begin
                if (primed_q[k] && (sample_in[k*WIDTH +: WIDTH] != last_q[k])
                        && (cnt_q[k] != CNT_MAX)) begin
                    cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                end
                last_q[k]   <= sample_in[k*WIDTH +: WIDTH];
                primed_q[k] <= 1'b1;
            end
        end
    end

    // Index decoders written as compare loops so an index wider than the
    // channel count simply misses instead of reading past the array.
    always_comb begin
        rd_sel   = '0;
        rd_hit   = 1'b0;
        scan_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_idx == IDX_W'(k)) begin
                rd_sel = cnt_q[k];
                rd_hit = 1'b1;
            end
            if (scan_idx_q == IDX_W'(k)) begin
                scan_sel = cnt_q[k];
            end
        end
        scan_hit = (scan_sel >= THRESH_C);
    end

    // Scan FSM: one channel per cycle, then DONE publishes the result.
    // A clear in SCAN or DONE abandons the scan and keeps the old summary.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            scan_idx_q    <= '0;
            acc_q         <= '0;
            covered_cnt   <= '0;
            all_covered   <= 1'b0;
            summary_valid <= 1'b0;
        end else begin
            summary_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (scan_req && !clear_req) begin
                        state_q    <= S_SCAN;
                        scan_idx_q <= '0;
                        acc_q      <= '0;
                    end
                end
                S_SCAN: begin
                    if (clear_req) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_q + SUM_W'(scan_hit);
                        if (scan_idx_q == IDX_W'(NUM_CH - 1)) begin
                            state_q <= S_DONE;
                        end else begin
                            scan_idx_q <= scan_idx_q + IDX_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    if (!clear_req) begin
                        covered_cnt   <= acc_q;
                        all_covered   <= (acc_q == SUM_W'(NUM_CH));
                        summary_valid <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign scan_busy = (state_q != S_IDLE);

    // Readout captures the counter as it stands in the request cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_cnt   <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            rd_err   <= rd_req && !rd_hit;
            rd_cnt   <= (rd_req && rd_hit) ? rd_sel : '0;
        end
    end

endmodule

// File: tb/tb_cov_toggle_collector.sv
// tb/tb_cov_toggle_collector.sv - directed vector bench for cov_toggle_collector
module tb_cov_toggle_collector;

    logic        clock = 1'b0;
    logic        reset;
    logic        cov_en;
    logic        clear_req;
    logic        scan_req;
    logic        rd_req;
    logic [2:0]  rd_idx;
    logic [63:0] sample_a;
    logic [63:0] sample_b;
    logic [47:0] sample_c;

    logic        scan_busy_a, summary_valid_a, all_covered_a, rd_valid_a, rd_err_a;
    logic [3:0]  covered_cnt_a;
    logic [15:0] rd_cnt_a;
    logic        scan_busy_b, summary_valid_b, all_covered_b, rd_valid_b, rd_err_b;
    logic [3:0]  covered_cnt_b;
    logic [1:0]  rd_cnt_b;
    logic        scan_busy_c, summary_valid_c, all_covered_c, rd_valid_c, rd_err_c;
    logic [2:0]  covered_cnt_c;
    logic [15:0] rd_cnt_c;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cov_toggle_collector dut_a (
        .clock(clock), .reset(reset), .cov_en(cov_en), .sample_in(sample_a),
        .clear_req(clear_req), .scan_req(scan_req), .scan_busy(scan_busy_a),
        .summary_valid(summary_valid_a), .covered_cnt(covered_cnt_a),
        .all_covered(all_covered_a), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_valid(rd_valid_a), .rd_cnt(rd_cnt_a), .rd_err(rd_err_a)
    );

    cov_toggle_collector #(.CNT_W(2), .THRESH(3)) dut_b (
        .clock(clock), .reset(reset), .cov_en(cov_en), .sample_in(sample_b),
        .clear_req(clear_req), .scan_req(scan_req), .scan_busy(scan_busy_b),
        .summary_valid(summary_valid_b), .covered_cnt(covered_cnt_b),
        .all_covered(all_covered_b), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_valid(rd_valid_b), .rd_cnt(rd_cnt_b), .rd_err(rd_err_b)
    );

    cov_toggle_collector #(.NUM_CH(6)) dut_c (
        .clock(clock), .reset(reset), .cov_en(cov_en), .sample_in(sample_c),
        .clear_req(clear_req), .scan_req(scan_req), .scan_busy(scan_busy_c),
        .summary_valid(summary_valid_c), .covered_cnt(covered_cnt_c),
        .all_covered(all_covered_c), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_valid(rd_valid_c), .rd_cnt(rd_cnt_c), .rd_err(rd_err_c)
    );

    typedef struct {
        logic        en;
        logic        clr;
        logic [7:0]  ch0;
        logic        rd;
        logic [2:0]  idx;
        logic        exp_valid;
        logic [15:0] exp_cnt;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        cov_en = 1'b0; clear_req = 1'b0; scan_req = 1'b0; rd_req = 1'b0; rd_idx = 3'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1; cov_en = 1'b1; clear_req = 1'b1; scan_req = 1'b1; rd_req = 1'b1;
        sample_a = 64'h1234_5678_9abc_def0; sample_b = '0; sample_c = '0;
        step(); step();
        reset = 1'b0; idle_inputs(); sample_a = '0;
    endtask

    function automatic logic sv_of(input int which);
        return (which == 0) ? summary_valid_a : summary_valid_b;
    endfunction

    // Pulses scan_req, re-pulses it while busy (must be ignored) and counts
    // edges after the accepting edge until summary_valid appears.
    task automatic scan_wait(input int which, output int n);
        scan_req = 1'b1;
        step();
        scan_req = 1'b0;
        chk("scan_busy_after_req", (which == 0) ? scan_busy_a : scan_busy_b, 1);
        n = 0;
        while (n < 40) begin
            scan_req = (n == 3);
            step();
            n++;
            if (sv_of(which)) break;
        end
        scan_req = 1'b0;
    endtask

    function automatic logic [63:0] mk_b(input logic [7:0] ch1, input logic [7:0] ch2);
        return {40'h0, ch2, ch1, 8'h00};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hits;
        idle_inputs();
        reset = 1'b1; sample_a = '0; sample_b = '0; sample_c = '0;

        // Reset overrides every request in the same cycle.
        do_reset();
        chk("rst_scan_busy", scan_busy_a, 0);
        chk("rst_summary_valid", summary_valid_a, 0);
        chk("rst_covered_cnt", covered_cnt_a, 0);
        chk("rst_all_covered", all_covered_a, 0);
        chk("rst_rd_valid", rd_valid_a, 0);
        chk("rst_rd_cnt", rd_cnt_a, 0);
        chk("rst_rd_err", rd_err_a, 0);

        // Table: ch0 toggling, enable gating, pre-update readout, clear/reprime.
        //          en    clr   ch0    rd    idx   ev    cnt     err
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 16'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'hFF, 1'b1, 3'd0, 1'b1, 16'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 16'd1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 8'hFF, 1'b1, 3'd0, 1'b1, 16'd2, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 16'd3, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 8'hFF, 1'b1, 3'd0, 1'b1, 16'd4, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 16'd0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, 16'd0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 8'hFF, 1'b1, 3'd0, 1'b1, 16'd4, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 16'd5, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 8'h00, 1'b1, 3'd0, 1'b1, 16'd5, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 8'hFF, 1'b1, 3'd0, 1'b1, 16'd0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 8'hFF, 1'b1, 3'd0, 1'b1, 16'd0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 16'd0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 16'd1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd7, 1'b1, 16'd0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            cov_en = vecs[i].en; clear_req = vecs[i].clr; rd_req = vecs[i].rd;
            rd_idx = vecs[i].idx; sample_a = {48'h0, 8'h5A, vecs[i].ch0};
            step();
            chk($sformatf("vec%0d_rd_valid", i), rd_valid_a, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_rd_cnt", i), rd_cnt_a, vecs[i].exp_cnt);
                chk($sformatf("vec%0d_rd_err", i), rd_err_a, vecs[i].exp_err);
            end
        end
        idle_inputs();

        // Scan: ch0 and ch3 toggled once -> 2 covered, latency 9.
        do_reset();
        cov_en = 1'b1; sample_a = '0; step();
        sample_a = 64'h0000_0000_FF00_00FF; step();
        cov_en = 1'b0;
        scan_wait(0, n);
        chk("scan1_latency", n, 9);
        chk("scan1_covered", covered_cnt_a, 2);
        chk("scan1_all", all_covered_a, 0);
        step();
        chk("scan1_pulse_drop", summary_valid_a, 0);
        chk("scan1_idle", scan_busy_a, 0);

        // Every channel toggled -> full coverage.
        cov_en = 1'b1; sample_a = {8{8'h0F}}; step();
        cov_en = 1'b0;
        scan_wait(0, n);
        chk("scan2_latency", n, 9);
        chk("scan2_covered", covered_cnt_a, 8);
        chk("scan2_all", all_covered_a, 1);

        // Clear four cycles into a scan aborts it and keeps the old summary.
        scan_req = 1'b1; step(); scan_req = 1'b0;
        step(); step(); step();
        clear_req = 1'b1; step(); clear_req = 1'b0;
        chk("abort_busy", scan_busy_a, 0);
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (summary_valid_a) hits++;
        end
        chk("abort_no_summary", hits, 0);
        chk("abort_covered_kept", covered_cnt_a, 8);
        chk("abort_all_kept", all_covered_a, 1);
        rd_req = 1'b1; rd_idx = 3'd0; step();
        chk("abort_cnt0", rd_cnt_a, 0);
        rd_idx = 3'd3; step();
        chk("abort_cnt3", rd_cnt_a, 0);
        rd_req = 1'b0;
        cov_en = 1'b1; sample_a = {8{8'hAA}}; step();
        sample_a = {8{8'h55}}; step();
        cov_en = 1'b0; rd_req = 1'b1; rd_idx = 3'd0; step();
        chk("post_clear_first_sample", rd_cnt_a, 1);
        rd_req = 1'b0;

        // CNT_W=2 saturation and THRESH=3 on instance b.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cov_en = 1'b1;
            sample_b = mk_b(8'h00, (i % 2 == 1) ? 8'hFF : 8'h00);
            step();
        end
        cov_en = 1'b0; rd_req = 1'b1; rd_idx = 3'd2; step();
        chk("sat_cnt", rd_cnt_b, 3);
        chk("sat_err", rd_err_b, 0);
        rd_req = 1'b0;
        cov_en = 1'b1; sample_b = mk_b(8'hFF, 8'hFF); step();
        sample_b = mk_b(8'h00, 8'hFF); step();
        cov_en = 1'b0;
        scan_wait(1, n);
        chk("thr1_latency", n, 9);
        chk("thr1_covered", covered_cnt_b, 1);
        chk("thr1_all", all_covered_b, 0);
        cov_en = 1'b1; sample_b = mk_b(8'hFF, 8'hFF); step();
        cov_en = 1'b0;
        scan_wait(1, n);
        chk("thr2_latency", n, 9);
        chk("thr2_covered", covered_cnt_b, 2);

        // NUM_CH=6: frozen counters under cov_en=0, back-to-back reads, range error.
        do_reset();
        cov_en = 1'b1; sample_c = '0; step();
        sample_c = {6{8'h11}}; step();
        cov_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample_c = {16'($urandom), $urandom};
            step();
        end
        rd_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rd_idx = 3'(k);
            step();
            chk($sformatf("c_rd%0d_valid", k), rd_valid_c, 1);
            chk($sformatf("c_rd%0d_cnt", k), rd_cnt_c, 1);
            chk($sformatf("c_rd%0d_err", k), rd_err_c, 0);
        end
        rd_idx = 3'd7; step();
        chk("c_oob7_valid", rd_valid_c, 1);
        chk("c_oob7_err", rd_err_c, 1);
        chk("c_oob7_cnt", rd_cnt_c, 0);
        rd_idx = 3'd6; step();
        chk("c_oob6_err", rd_err_c, 1);
        rd_req = 1'b0; step();
        chk("c_rd_idle", rd_valid_c, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
